// File: rtl/datapath_sequencer.sv
// Instruction-level controller for the register-file/ALU/shifter datapath.
// Latches a 16-bit instruction and sequences every datapath control line through a Moore FSM.
module datapath_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic        illegal,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_EXEC      = 3'd4,
        S_EXEC_CMP  = 3'd5,
        S_WRITE_RD  = 3'd6,
        S_WRITE_IMM = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;

    // Instruction fields
    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [2:0] w_rm;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_rm     = r_ir[2:0];

    assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};
    assign shift  = r_ir[4:3];

    logic w_is_mov_imm;
    logic w_is_mov_reg;
    logic w_is_alu;
    logic w_is_cmp;
    logic w_is_mvn;

    assign w_is_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_is_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_is_alu     = (w_opcode == 3'b101);
    assign w_is_cmp     = w_is_alu && (w_op == 2'b01);
    assign w_is_mvn     = w_is_alu && (w_op == 2'b11);

    // IR only loads in WAIT so it stays stable for the whole instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next;
            if ((r_state == S_WAIT) && load) begin
                r_ir <= in;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT: begin
                if (s) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_is_mov_imm)                 w_next = S_WRITE_IMM;
                else if (w_is_mov_reg || w_is_mvn) w_next = S_GET_B;
                else if (w_is_alu)                 w_next = S_GET_A;
                else                               w_next = S_WAIT;
            end
            S_GET_A:     w_next = S_GET_B;
            S_GET_B:     w_next = w_is_cmp ? S_EXEC_CMP : S_EXEC;
            S_EXEC:      w_next = S_WRITE_RD;
            S_EXEC_CMP:  w_next = S_WAIT;
            S_WRITE_RD:  w_next = S_WAIT;
            S_WRITE_IMM: w_next = S_WAIT;
            default:     w_next = S_WAIT;
        endcase
    end

    // Raw per-state controls, before the reset override.
    logic       w_illegal;
    logic [2:0] w_readnum;
    logic [2:0] w_writenum;
    logic       w_write;
    logic [1:0] w_vsel;
    logic       w_loada;
    logic       w_loadb;
    logic       w_loadc;
    logic       w_loads;
    logic       w_asel;
    logic [1:0] w_aluop;

    always_comb begin
        w_illegal  = 1'b0;
        w_readnum  = 3'd0;
        w_writenum = 3'd0;
        w_write    = 1'b0;
        w_vsel     = 2'b00;
        w_loada    = 1'b0;
        w_loadb    = 1'b0;
        w_loadc    = 1'b0;
        w_loads    = 1'b0;
        w_asel     = 1'b0;
        w_aluop    = 2'b00;
        case (r_state)
            S_DECODE: begin
                w_illegal = !(w_is_mov_imm || w_is_mov_reg || w_is_alu);
            end
            S_GET_A: begin
                w_readnum = w_rn;
                w_loada   = 1'b1;
            end
            S_GET_B: begin
                w_readnum = w_rm;
                w_loadb   = 1'b1;
            end
            S_EXEC: begin
                w_loadc = 1'b1;
                w_asel  = w_is_mov_reg;
                w_aluop = w_is_mov_reg ? 2'b00 : w_op;
            end
            S_EXEC_CMP: begin
                w_aluop = 2'b01;
                w_loads = 1'b1;
            end
            S_WRITE_RD: begin
                w_writenum = w_rd;
                w_write    = 1'b1;
            end
            S_WRITE_IMM: begin
                w_writenum = w_rn;
                w_vsel     = 2'b10;
                w_write    = 1'b1;
            end
            default: begin
                w_illegal = 1'b0;
            end
        endcase
    end

    // Reset masks controls in the same cycle so a pending write never lands.
    always_comb begin
        illegal  = w_illegal  & ~reset;
        readnum  = reset ? 3'd0  : w_readnum;
        writenum = reset ? 3'd0  : w_writenum;
        write    = w_write    & ~reset;
        vsel     = reset ? 2'b00 : w_vsel;
        loada    = w_loada    & ~reset;
        loadb    = w_loadb    & ~reset;
        loadc    = w_loadc    & ~reset;
        loads    = w_loads    & ~reset;
        asel     = w_asel     & ~reset;
        ALUop    = reset ? 2'b00 : w_aluop;
    end

    assign bsel        = 1'b0;
    assign w           = (r_state == S_WAIT);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed scenarios plus random instructions,
// each compared cycle by cycle against an instruction-level expected control sequence.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic        illegal;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [2:0]  dbg_state;

    datapath_sequencer dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .w(w), .illegal(illegal), .readnum(readnum), .writenum(writenum),
        .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .shift(shift), .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic       ill;
        logic [2:0] rnum;
        logic [2:0] wnum;
        logic       wr;
        logic [1:0] vsel;
        logic       la;
        logic       lb;
        logic       lc;
        logic       ls;
        logic       asel;
        logic       bsel;
        logic [1:0] sh;
        logic [1:0] alu;
    } ctrl_t;

    ctrl_t obs;
    assign obs = '{w: w, ill: illegal, rnum: readnum, wnum: writenum, wr: write,
                   vsel: vsel, la: loada, lb: loadb, lc: loadc, ls: loads,
                   asel: asel, bsel: bsel, sh: shift, alu: ALUop};

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_ir;
    logic [20:0] exp_q[$];

    task automatic chk(input string tag, input logic [20:0] o, input logic [20:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check_out(input string tag, input ctrl_t e);
        logic [15:0] e8;
        logic [15:0] e5;
        e8 = m_ir[7] ? (16'hFF00 | {8'h00, m_ir[7:0]}) : {8'h00, m_ir[7:0]};
        e5 = m_ir[4] ? (16'hFFE0 | {11'h000, m_ir[4:0]}) : {11'h000, m_ir[4:0]};
        chk({tag, " ctrl"}, obs, e);
        chk({tag, " sximm8"}, {5'd0, sximm8}, {5'd0, e8});
        chk({tag, " sximm5"}, {5'd0, sximm5}, {5'd0, e5});
    endtask

    function automatic ctrl_t idle_ctrl(input logic is_wait, input logic [15:0] ir);
        ctrl_t c;
        c = '0;
        c.w  = is_wait;
        c.sh = ir[4:3];
        return c;
    endfunction

    // Expected busy-cycle controls of one instruction, straight from its semantics.
    function automatic void build_seq(input logic [15:0] ir);
        ctrl_t c;
        logic [2:0] opc;
        logic [1:0] op;
        logic mov_imm, mov_reg, mvn, alu;
        opc = ir[15:13];
        op  = ir[12:11];
        mov_imm = (opc == 3'b110) && (op == 2'b10);
        mov_reg = (opc == 3'b110) && (op == 2'b00);
        alu     = (opc == 3'b101);
        mvn     = alu && (op == 2'b11);
        exp_q.delete();
        c = idle_ctrl(1'b0, ir);
        c.ill = !(mov_imm || mov_reg || alu);
        exp_q.push_back(c);
        if (mov_imm) begin
            c = idle_ctrl(1'b0, ir);
            c.wnum = ir[10:8]; c.vsel = 2'b10; c.wr = 1'b1;
            exp_q.push_back(c);
        end else if (mov_reg || alu) begin
            if (!(mov_reg || mvn)) begin
                c = idle_ctrl(1'b0, ir);
                c.rnum = ir[10:8]; c.la = 1'b1;
                exp_q.push_back(c);
            end
            c = idle_ctrl(1'b0, ir);
            c.rnum = ir[2:0]; c.lb = 1'b1;
            exp_q.push_back(c);
            if (alu && op == 2'b01) begin
                c = idle_ctrl(1'b0, ir);
                c.alu = 2'b01; c.ls = 1'b1;
                exp_q.push_back(c);
            end else begin
                c = idle_ctrl(1'b0, ir);
                c.lc = 1'b1;
                c.asel = mov_reg;
                c.alu = mov_reg ? 2'b00 : op;
                exp_q.push_back(c);
                c = idle_ctrl(1'b0, ir);
                c.wnum = ir[7:5]; c.wr = 1'b1;
                exp_q.push_back(c);
            end
        end
    endfunction

    // Called at posedge+1 of a WAIT cycle; returns at posedge+1 of the next WAIT cycle.
    // busy_mode: 0 no load while busy, 1 load busy_in every busy cycle, 2 random loads.
    task automatic run_instr(input logic [15:0] instr, input bit do_load, input bit s_hold,
                             input int busy_mode, input logic [15:0] busy_in, input int rst_step);
        int n;
        in = instr; load = do_load; s = 1'b1;
        @(negedge clk);
        check_out($sformatf("wait-before ir=%h", m_ir), idle_ctrl(1'b1, m_ir));
        @(posedge clk);
        if (do_load) m_ir = instr;
        #1;
        build_seq(m_ir);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            s    = s_hold;
            load = (busy_mode == 1) ? 1'b1 : (busy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            in   = (busy_mode == 1) ? busy_in : 16'($urandom);
            if (i == rst_step) reset = 1'b1;
            @(negedge clk);
            if (i == rst_step) begin
                check_out($sformatf("reset-step%0d ir=%h", i, m_ir), idle_ctrl(1'b0, m_ir));
                @(posedge clk);
                m_ir = 16'h0000;
                #1;
                reset = 1'b0;
                load  = 1'b0;
                s     = 1'b0;
                return;
            end
            check_out($sformatf("step%0d ir=%h", i, m_ir), ctrl_t'(exp_q.pop_front()));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n, input bit allow_load);
        for (int i = 0; i < n; i++) begin
            s    = 1'b0;
            load = allow_load ? 1'($urandom_range(0, 1)) : 1'b0;
            in   = 16'($urandom);
            @(negedge clk);
            check_out($sformatf("idle ir=%h", m_ir), idle_ctrl(1'b1, m_ir));
            @(posedge clk);
            if (load) m_ir = in;
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [15:0] r;
        int k;
        reset = 1'b1; s = 1'b1; load = 1'b1; in = 16'hFFFF;
        m_ir = 16'h0000;
        @(posedge clk); #1;
        @(negedge clk);
        check_out("in-reset", idle_ctrl(1'b1, 16'h0000));
        @(posedge clk); #1;
        reset = 1'b0; s = 1'b0; load = 1'b0;
        idle(2, 1'b0);

        run_instr(16'hD007, 1, 0, 0, 16'h0, -1);   // MOV R0,#7
        run_instr(16'hD1FE, 1, 0, 0, 16'h0, -1);   // MOV R1,#-2
        run_instr(16'hA148, 1, 0, 0, 16'h0, -1);   // ADD R2,R1,R0,LSL#1
        run_instr(16'hC0A3, 1, 0, 0, 16'h0, -1);   // MOV R5,R3
        run_instr(16'hB8F9, 1, 0, 0, 16'h0, -1);   // MVN R7,R1,sh
        run_instr(16'hB345, 1, 0, 0, 16'h0, -1);   // AND R2,R3,R5
        run_instr(16'hA900, 1, 1, 0, 16'h0, -1);   // CMP R1,R0 with s held
        run_instr(16'hFFFF, 0, 0, 0, 16'h0, -1);   // immediate re-run of CMP
        idle(1, 1'b0);
        run_instr(16'h0000, 1, 0, 0, 16'h0, -1);   // illegal
        run_instr(16'hD800, 1, 0, 0, 16'h0, -1);   // illegal 110/11
        run_instr(16'hA148, 1, 0, 0, 16'h0, 2);    // reset in GET_B
        idle(1, 1'b0);
        run_instr(16'hA148, 1, 0, 1, 16'hD0FF, -1); // load while busy ignored
        idle(1, 1'b0);

        for (int it = 0; it < 60; it++) begin
            r = 16'($urandom);
            k = $urandom_range(0, 7);
            case (k)
                0: r[15:11] = 5'b11010;
                1: r[15:11] = 5'b11000;
                2, 3, 4, 5: r[15:11] = {3'b101, 2'(k - 2)};
                default: ;
            endcase
            run_instr(r, 1, 1'($urandom_range(0, 1)), 2, 16'h0,
                      ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : -1);
            idle($urandom_range(0, 2), 1'b1);
        end
        idle(1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Instruction-level controller for the register-file/ALU/shifter datapath. It latches a 16-bit instruction, decodes its fields, and runs a Moore state machine that drives every datapath control line (register reads and writes, pipeline-register loads, operand selects, ALU op, shift, status load). The `s`/`w` start/wait handshake makes it the single owner of the datapath: it sits between the instruction source and the datapath.

## Interface
- Parameters: none.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `s` in 1: start request, sampled only in WAIT.
- `load` in 1: instruction-register load enable, honoured only in WAIT.
- `in` in 16: instruction word.
- `w` out 1: 1 exactly when in WAIT (idle, ready).
- `illegal` out 1: 1-cycle pulse on an undefined opcode/op.
- `readnum` out 3, `writenum` out 3, `write` out 1: register-file controls.
- `vsel` out 2: writeback source (00 = C register, 10 = sximm8).
- `loada`, `loadb`, `loadc`, `loads` out 1 each: datapath register loads.
- `asel`, `bsel` out 1 each: operand selects (1 = Ain zero / Bin sximm5).
- `shift` out 2: shifter control.
- `ALUop` out 2: ALU operation.
- `sximm8` out 16: sign-extended `IR[7:0]`.
- `sximm5` out 16: sign-extended `IR[4:0]`.

## Operation
- **Instruction register (IR)**
  - Loads `in` on an edge with `load=1` and state WAIT; otherwise holds.
- **IR fields**
  - opcode `[15:13]`, op `[12:11]`, Rn `[10:8]`, Rd `[7:5]`, sh `[4:3]`, Rm `[2:0]`, imm8 `[7:0]`, imm5 `[4:0]`.
  - `sximm8`, `sximm5` and `shift = sh` are continuous decodes of IR, valid in every state.
- **Instructions**
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm{,sh}
  - 101/01 CMP Rn,Rm{,sh}
  - 101/10 AND
  - 101/11 MVN Rd,Rm{,sh}
  - All other opcode/op combinations are illegal.
- **States:** WAIT, DECODE, GET_A, GET_B, EXEC, EXEC_CMP, WRITE_RD, WRITE_IMM.
- **Transitions**
  - WAIT → DECODE when `s=1`, else stay.
  - DECODE → WRITE_IMM (MOV imm), GET_B (MOV reg, MVN), GET_A (ADD, AND, CMP), or WAIT (illegal, with `illegal=1` in DECODE).
  - GET_A → GET_B.
  - GET_B → EXEC_CMP for CMP, else EXEC.
  - EXEC → WRITE_RD.
  - WRITE_RD, WRITE_IMM, EXEC_CMP → WAIT.
- **Per-state outputs** (every unlisted control is 0)
  - GET_A: `readnum=Rn`, `loada=1`.
  - GET_B: `readnum=Rm`, `loadb=1`.
  - EXEC: `loadc=1`, `bsel=0`.
    - MOV reg: `asel=1`, `ALUop=00`.
    - ADD/AND/MVN: `asel=0`, `ALUop=op`.
  - EXEC_CMP: `asel=0`, `ALUop=01`, `loads=1`.
  - WRITE_RD: `writenum=Rd`, `vsel=00`, `write=1`.
  - WRITE_IMM: `writenum=Rn`, `vsel=10`, `write=1`.
- **Idle values:** `readnum`/`writenum` are 0 when unused. `bsel` is always 0 for the current instruction set; the port is reserved.

## Timing
- **Reset**
  - `reset=1` at an edge: state ← WAIT, IR ← 0.
  - While `reset=1`, all control outputs (load*, `write`, `illegal`, selects, `ALUop`, `vsel`, `readnum`, `writenum`) are forced to 0. A reset arriving mid-instruction therefore never completes a pending register write.
  - `w=1` from the first cycle after the reset edge.
- **Latency** (counted from edge E0 where WAIT samples `s=1`): busy cycles with `w=0` are
  - MOV imm 2,
  - MOV reg / MVN 4,
  - CMP 4,
  - ADD / AND 5,
  - illegal 1.
- **Write timing:** the register write occurs on the edge that leaves WRITE_*. `w` returns to 1 in the following cycle.
- **`load` and `s` together:** with `load=1` and `s=1` in the same WAIT cycle, IR captures the new word at E0 and DECODE uses it.
- **`s` is level-sensitive:** if `s` is still 1 in the first WAIT cycle after completion, the next instruction (the IR contents) starts immediately.
- **`load` while busy** is ignored, so the IR is stable for the entire instruction.

## Test plan
- **MOV imm:** reset; `in=0xD007`, `load=1`, `s=1` for one cycle.
  - Expect DECODE, then WRITE_IMM with `write=1`, `writenum=0`, `vsel=10`, `sximm8=0x0007`.
  - Expect `w=0` for exactly 2 cycles.
- **MOV imm, negative:** `in=0xD1FE`.
  - Expect `sximm8=0xFFFE`, `writenum=1`.
- **ADD with shift:** `in=0xA148` (ADD R2,R1,R0,LSL#1).
  - GET_A: `readnum=1`, `loada`.
  - GET_B: `readnum=0`, `loadb`.
  - EXEC: `ALUop=00`, `shift=01`, `asel=0`, `loadc`.
  - WRITE_RD: `writenum=2`.
  - Expect `w=0` for 5 cycles.
- **CMP and repeat start:** `in=0xA900` (CMP R1,R0), `s` held 1 throughout.
  - Expect `loads=1` only in EXEC_CMP, `ALUop=01`, `write` never asserted.
  - Expect re-execution to start on the first WAIT cycle.
- **Illegal opcode:** `in=0x0000`.
  - Expect `illegal=1` for one cycle in DECODE, back to WAIT, no load/write asserted.
- **Reset and busy load:**
  - During an ADD, assert `reset` in the GET_B cycle: all controls 0 that cycle, `w=1` next cycle, `sximm8=0`.
  - Separately, pulse `load` with `0xD0FF` mid-ADD: IR unchanged, ADD completes as specified.
